// File: rtl/sram_like_bridge.sv
// CPU SRAM-port to SRAM-like bus bridge: captures one access, runs the
// req/addr_ok/data_ok handshake, and drains accepted transactions on flush.
module sram_like_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  stall,
  input  logic                  sram_en,
  input  logic [DATA_W/8-1:0]   sram_wen,
  input  logic [1:0]            sram_size,
  input  logic [ADDR_W-1:0]     sram_addr,
  input  logic [DATA_W-1:0]     sram_wdata,
  output logic [DATA_W-1:0]     sram_rdata,
  output logic                  err_wen,
  output logic                  req,
  output logic                  wr,
  output logic [1:0]            size,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     wdata,
  input  logic                  addr_ok,
  input  logic                  data_ok,
  input  logic [DATA_W-1:0]     rdata
);

  localparam int WB   = DATA_W / 8;
  localparam int LGWB = $clog2(WB);
  localparam int RW   = LGWB + 3;

  localparam logic [WB-1:0] ONE_L   = WB'(1'b1);
  localparam logic [WB-1:0] PAIR_L  = WB'(2'b11);
  localparam logic [WB-1:0] QUAD_L  = WB'(4'hF);
  localparam logic [WB-1:0] ALL_L   = {WB{1'b1}};
  localparam logic [1:0]    FULL_SZ = (DATA_W == 64) ? 2'd3 : 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Maps a byte-enable pattern to {error, size, lane offset}; unrecognised
  // patterns fall back to a full-width aligned transfer flagged as an error.
  function automatic logic [RW-1:0] wr_derive(input logic [WB-1:0] wen);
    logic [RW-1:0] res;
    res = {1'b1, FULL_SZ, {LGWB{1'b0}}};
    for (int k = 0; k < WB; k++) begin
      if (wen == (ONE_L << k)) begin
        res = {1'b0, 2'd0, LGWB'(k)};
      end
    end
    for (int k = 0; k < WB / 2; k++) begin
      if (wen == (PAIR_L << (2 * k))) begin
        res = {1'b0, 2'd1, LGWB'(2 * k)};
      end
    end
    for (int k = 0; k < WB / 4; k++) begin
      if (wen == (QUAD_L << (4 * k))) begin
        res = {1'b0, 2'd2, LGWB'(4 * k)};
      end
    end
    if ((WB == 8) && (wen == ALL_L)) begin
      res = {1'b0, 2'd3, {LGWB{1'b0}}};
    end
    return res;
  endfunction

  state_t              state_q;
  logic                req_q;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   sram_rdata_q;
  logic                err_wen_q;

  logic [RW-1:0]       wder_s;
  logic                cap_wr_s;
  logic [1:0]          cap_size_s;
  logic [ADDR_W-1:0]   cap_addr_s;
  logic                cap_err_s;

  // Request fields as they would be captured this cycle.
  always_comb begin
    wder_s   = wr_derive(sram_wen);
    cap_wr_s = |sram_wen;
    if (cap_wr_s) begin
      cap_size_s = wder_s[RW-2 -: 2];
      cap_addr_s = {sram_addr[ADDR_W-1:LGWB], wder_s[LGWB-1:0]};
      cap_err_s  = wder_s[RW-1];
    end else begin
      cap_size_s = sram_size;
      cap_addr_s = sram_addr;
      cap_err_s  = 1'b0;
    end
  end

  // Bridge FSM with all bus-facing outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sram_rdata_q <= '0;
      err_wen_q    <= 1'b0;
    end else begin
      err_wen_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sram_en && !flush) begin
            state_q   <= ADDR;
            req_q     <= 1'b1;
            wr_q      <= cap_wr_s;
            size_q    <= cap_size_s;
            addr_q    <= cap_addr_s;
            wdata_q   <= sram_wdata;
            err_wen_q <= cap_err_s;
          end else begin
            state_q <= IDLE;
          end
        end
        ADDR: begin
          if (flush) begin
            // Only an accepted request still owes a data_ok that must be drained.
            req_q   <= 1'b0;
            state_q <= (addr_ok && !data_ok) ? DRAIN : IDLE;
          end else if (addr_ok) begin
            req_q <= 1'b0;
            if (data_ok) begin
              state_q <= DONE;
              if (!wr_q) begin
                sram_rdata_q <= rdata;
              end else begin
                sram_rdata_q <= sram_rdata_q;
              end
            end else begin
              state_q <= DATA;
            end
          end else begin
            state_q <= ADDR;
          end
        end
        DATA: begin
          if (flush) begin
            state_q <= data_ok ? IDLE : DRAIN;
          end else if (data_ok) begin
            state_q <= DONE;
            if (!wr_q) begin
              sram_rdata_q <= rdata;
            end else begin
              sram_rdata_q <= sram_rdata_q;
            end
          end else begin
            state_q <= DATA;
          end
        end
        DONE: begin
          if (flush || !hold) begin
            state_q <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        DRAIN: begin
          if (data_ok) begin
            state_q <= IDLE;
          end else begin
            state_q <= DRAIN;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign stall      = sram_en & ~flush & (state_q != DONE);
  assign sram_rdata = sram_rdata_q;
  assign err_wen    = err_wen_q;
  assign req        = req_q;
  assign wr         = wr_q;
  assign size       = size_q;
  assign addr       = addr_q;
  assign wdata      = wdata_q;

endmodule

// File: doc/sram_like_bridge.md
# sram_like_bridge

Parametrised SRAM-to-SRAM-like protocol bridge. It sits between a CPU memory port, which uses an enable/byte-write-enable/address/data interface and stalls the pipeline, and the SRAM-like bus with req/addr_ok/data_ok handshakes. It is a single replacement for the separate instruction-side and data-side bridges. Over those it adds:
- configurable data width;
- explicit read size;
- byte-enable-to-size/address derivation;
- registered request capture;
- a flush path that drains already-accepted transactions.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; legal values are 32 and 64. WB = DATA_W/8 is the number of byte lanes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- hold  in  1  pipeline-wide stall; keeps the completed result presented.
- flush  in  1  exception flush; abandons the current access.
- stall  out  1  access in progress; CPU must freeze.
- sram_en  in  1  access request, held stable by the CPU while stall is high.
- sram_wen  in  WB  byte write enables; 0 means read.
- sram_size  in  2  read size: 0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64).
- sram_addr  in  ADDR_W  byte address.
- sram_wdata  in  DATA_W  write data.
- sram_rdata  out  DATA_W  read data of the last completed read.
- err_wen  out  1  one-cycle pulse: non-contiguous sram_wen was captured.
- req  out  1  bus request.
- wr  out  1  1 = write.
- size  out  2  bus transfer size.
- addr  out  ADDR_W  bus address.
- wdata  out  DATA_W  bus write data.
- addr_ok  in  1  request accepted.
- data_ok  in  1  data returned / write done.
- rdata  in  DATA_W  bus read data.

## Operation

States: IDLE, ADDR, DATA, DONE, DRAIN. All outputs reset to 0; state resets to IDLE.

Capture (IDLE, sram_en=1, flush=0):
- Register wr=|sram_wen, size, addr, wdata; next state is ADDR.
- These registers stay unchanged until the next capture.

Size/address derivation for writes:
- Single byte lane k: size=0, addr = {sram_addr[ADDR_W-1:log2(WB)], k}.
- Aligned lane pair {2j, 2j+1}: size=1, low address bits = 2j.
- Aligned 4-lane group: size=2, aligned to 4.
- All lanes set with DATA_W=64: size=3.
- Any other pattern: size = full width, address aligned to WB, err_wen pulses in the cycle after capture.

Reads: size comes from sram_size; addr = sram_addr unmodified.

State transitions:
- ADDR: req=1. On addr_ok & data_ok go to DONE. On addr_ok alone go to DATA.
- DATA: req=0. On data_ok go to DONE.
- Data capture: on the data_ok that completes a non-flushed read, sram_rdata <= rdata. Writes leave sram_rdata unchanged.
- DONE: result is valid. If hold=1, stay in DONE. If hold=0, go to IDLE.
- IDLE→ADDR requires sram_en in IDLE only. Re-entering IDLE with sram_en still high starts a new access, so the CPU drops sram_en or advances the PC while hold=0.

Flush (highest priority):
- IDLE or DONE: go to IDLE, no bus activity.
- ADDR without addr_ok: go to IDLE; req drops next cycle (request withdrawn before acceptance).
- ADDR with addr_ok and without data_ok: go to DRAIN.
- DATA without data_ok: go to DRAIN.
- Flush in the same cycle as data_ok (ADDR or DATA): go to IDLE, data discarded, sram_rdata unchanged.
- DRAIN: req=0; wait for data_ok, discard it, go to IDLE. Flush in DRAIN has no further effect.

stall is combinational:
- stall = sram_en & ~flush & (state ∈ {IDLE, ADDR, DATA, DRAIN}).
- stall is 0 in DONE.
- With sram_en=0, stall=0 in every state, including DRAIN.

At most one outstanding bus transaction exists at any time. req never asserts in DATA, DONE or DRAIN.

## Timing
- Minimum read latency, with addr_ok in the first req cycle and data_ok one cycle later:
  - sram_en at cycle 0, req high at cycle 1, data_ok at cycle 2.
  - DONE at cycle 3: stall low, sram_rdata valid.
  - stall high for cycles 0–2.
- With addr_ok and data_ok together at cycle 1, DONE is at cycle 2.
- req, wr, size, addr, wdata are registered and stable from capture until addr_ok.
- err_wen lasts exactly one cycle.
- Reset asserted mid-transaction: immediate return to IDLE with req=0. The bus is expected to be reset together with the bridge.

## Test plan
1. Word read, DATA_W=32, addr 0x1000:
   - Stimulus: addr_ok at cycle 1, data_ok with rdata 0xDEADBEEF at cycle 2.
   - Required: req only at cycle 1, size=2, stall high cycles 0–2, sram_rdata=0xDEADBEEF at cycle 3.
2. Write derivation:
   - sram_wen=0100, addr 0x2000 → wr=1, size=0, addr=0x2002.
   - sram_wen=1100 → size=1, addr=0x2002.
   - sram_wen=0101 → size=2, addr=0x2000, err_wen single pulse.
3. hold=1 for 4 cycles after DONE:
   - Required: stall low, sram_rdata stable, no req.
   - Then hold=0 with sram_en=0 → IDLE, no new access.
4. Flush in ADDR without addr_ok:
   - Required: req drops next cycle, return to IDLE, stall low during the flush cycle.
   - A subsequent read issues normally.
5. Flush in DATA, then data_ok 3 cycles later with rdata 0x12345678:
   - Required: DRAIN, sram_rdata unchanged, no req until IDLE.
   - A following read returns its own data.
6. DATA_W=64:
   - sram_wen=FF → size=3, addr aligned to 8.
   - Read with sram_size=3 returns the full 64-bit rdata.
   - Back-to-back accesses with random addr_ok/data_ok delays (0–5 cycles) show no lost or duplicated transactions.
